// File: rtl/msg_splitter3_narrow.sv
// ---------------------------------------------------------------------------
// msg_splitter3_narrow
//
// Steers one narrow message stream to three narrow output channels (a, b, c)
// according to a 2-bit destination code. Each channel owns a small FIFO, so a
// stalled consumer only back-pressures messages aimed at its own channel.
// Messages with destination 0 are consumed and dropped, and are counted in a
// saturating 8-bit counter.
//
// A message is valid when its value differs from NOTLEGAL (all ones). A
// transfer happens on the rising clk edge where the value is valid and the
// receiver's ack is high.
//
// Ports:
//   clk         clock
//   rst_n       synchronous active-low reset
//   msgin       incoming message, NOTLEGAL = no message
//   msgdst      destination: 1=a, 2=b, 3=c, 0=discard
//   msgin_ack   msgin is consumed on this edge (combinational)
//   msga/b/c    channel head, NOTLEGAL when the channel FIFO is empty
//   msga/b/c_ack consumer takes the channel head on this edge
//   drop_count  number of discarded messages, saturates at 255
// ---------------------------------------------------------------------------
module msg_splitter3_narrow #(
   parameter int WBUFS     = 6,
   parameter int DEPTH_LOG = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WBUFS-1:0] msgin,
   input  logic [1:0]       msgdst,
   output logic             msgin_ack,
   output logic [WBUFS-1:0] msga,
   output logic [WBUFS-1:0] msgb,
   output logic [WBUFS-1:0] msgc,
   input  logic             msga_ack,
   input  logic             msgb_ack,
   input  logic             msgc_ack,
   output logic [7:0]       drop_count
);

   localparam logic [WBUFS-1:0] NOTLEGAL  = '1;
   localparam int               DEPTH     = 1 << DEPTH_LOG;
   localparam logic [DEPTH_LOG:0]   DEPTH_CNT = (DEPTH_LOG+1)'(DEPTH);
   localparam logic [DEPTH_LOG:0]   CNT_ONE   = (DEPTH_LOG+1)'(1);
   localparam logic [DEPTH_LOG-1:0] PTR_ONE   = DEPTH_LOG'(1);

   // Saturating increment for the discard counter.
   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   // Per-channel FIFO state (index 0=a, 1=b, 2=c).
   logic [WBUFS-1:0]     mem    [3][DEPTH];
   logic [DEPTH_LOG-1:0] wr_ptr [3];
   logic [DEPTH_LOG-1:0] rd_ptr [3];
   logic [DEPTH_LOG:0]   cnt    [3];

   logic [2:0]       full;
   logic [2:0]       push;
   logic [2:0]       pop;
   logic [2:0]       ack_v;
   logic [WBUFS-1:0] head [3];
   logic             in_vld;
   logic             sel_full;
   logic             drop;
   logic [7:0]       drop_cnt;

   assign ack_v  = {msgc_ack, msgb_ack, msga_ack};
   assign in_vld = (msgin != NOTLEGAL);

   always_comb begin
      for (int ch = 0; ch < 3; ch++) begin
         full[ch] = (cnt[ch] == DEPTH_CNT);
      end
   end

   always_comb begin
      sel_full = 1'b0;
      case (msgdst)
         2'd1:    sel_full = full[0];
         2'd2:    sel_full = full[1];
         2'd3:    sel_full = full[2];
         default: sel_full = 1'b0;
      endcase
   end

   // Acceptance looks only at the current count; a pop in the same cycle does
   // not free room for a push into a full FIFO.
   assign msgin_ack = rst_n && in_vld && ((msgdst == 2'd0) || !sel_full);
   assign drop      = msgin_ack && (msgdst == 2'd0);

   always_comb begin
      for (int ch = 0; ch < 3; ch++) begin
         push[ch] = msgin_ack && (msgdst == 2'(ch + 1));
         // An ack against an empty channel is ignored.
         pop[ch]  = ack_v[ch] && (cnt[ch] != '0);
         head[ch] = (cnt[ch] != '0) ? mem[ch][rd_ptr[ch]] : NOTLEGAL;
      end
   end

   assign msga       = head[0];
   assign msgb       = head[1];
   assign msgc       = head[2];
   assign drop_count = drop_cnt;

   // ---- control state: pointers, counts, discard counter ----
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int ch = 0; ch < 3; ch++) begin
            wr_ptr[ch] <= '0;
            rd_ptr[ch] <= '0;
            cnt[ch]    <= '0;
         end
         drop_cnt <= '0;
      end else begin
         for (int ch = 0; ch < 3; ch++) begin
            if (push[ch]) wr_ptr[ch] <= wr_ptr[ch] + PTR_ONE;
            if (pop[ch])  rd_ptr[ch] <= rd_ptr[ch] + PTR_ONE;
            if (push[ch] && !pop[ch])
               cnt[ch] <= cnt[ch] + CNT_ONE;
            else if (pop[ch] && !push[ch])
               cnt[ch] <= cnt[ch] - CNT_ONE;
         end
         if (drop) drop_cnt <= sat_inc8(drop_cnt);
      end
   end

   // ---- data storage: written on push, never reset ----
   always_ff @(posedge clk) begin
      for (int ch = 0; ch < 3; ch++) begin
         if (push[ch]) mem[ch][wr_ptr[ch]] <= msgin;
      end
   end

endmodule

// File: tb/tb_msg_splitter3_narrow.sv
// ---------------------------------------------------------------------------
// Testbench for msg_splitter3_narrow: directed scenarios followed by random
// traffic, all compared against a queue-based reference model.
// ---------------------------------------------------------------------------
module tb_msg_splitter3_narrow;

   localparam logic [5:0] IDLE = 6'd63;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [5:0] msgin;
   logic [1:0] msgdst;
   logic       msgin_ack;
   logic [5:0] msga, msgb, msgc;
   logic       msga_ack, msgb_ack, msgc_ack;
   logic [7:0] drop_count;

   msg_splitter3_narrow #(.WBUFS(6), .DEPTH_LOG(1)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .msgin      (msgin),
      .msgdst     (msgdst),
      .msgin_ack  (msgin_ack),
      .msga       (msga),
      .msgb       (msgb),
      .msgc       (msgc),
      .msga_ack   (msga_ack),
      .msgb_ack   (msgb_ack),
      .msgc_ack   (msgc_ack),
      .drop_count (drop_count)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // Reference model: one queue per channel plus a saturating drop counter.
   logic [5:0] qa[$];
   logic [5:0] qb[$];
   logic [5:0] qc[$];
   int         m_drop = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int qsize(input int ch);
      case (ch)
         0:       return qa.size();
         1:       return qb.size();
         default: return qc.size();
      endcase
   endfunction

   function automatic logic [5:0] qhead(input int ch);
      case (ch)
         0:       return (qa.size() > 0) ? qa[0] : IDLE;
         1:       return (qb.size() > 0) ? qb[0] : IDLE;
         default: return (qc.size() > 0) ? qc[0] : IDLE;
      endcase
   endfunction

   // One clock cycle: drive, check combinational/registered outputs, then
   // advance the model across the rising edge.
   task automatic step(input logic [5:0] m, input logic [1:0] d,
                       input logic aa, input logic ab, input logic ac,
                       input logic rn);
      logic exp_ack;
      @(negedge clk);
      rst_n    = rn;
      msgin    = m;
      msgdst   = d;
      msga_ack = aa;
      msgb_ack = ab;
      msgc_ack = ac;
      #1;
      exp_ack = rn && (m != IDLE) && ((d == 2'd0) || (qsize(int'(d) - 1) < 2));
      check_eq("msgin_ack",  {31'd0, msgin_ack}, {31'd0, exp_ack});
      check_eq("msga",       {26'd0, msga}, {26'd0, qhead(0)});
      check_eq("msgb",       {26'd0, msgb}, {26'd0, qhead(1)});
      check_eq("msgc",       {26'd0, msgc}, {26'd0, qhead(2)});
      check_eq("drop_count", {24'd0, drop_count}, m_drop);
      @(posedge clk);
      if (!rn) begin
         qa.delete(); qb.delete(); qc.delete();
         m_drop = 0;
      end else begin
         if (aa && qa.size() > 0) void'(qa.pop_front());
         if (ab && qb.size() > 0) void'(qb.pop_front());
         if (ac && qc.size() > 0) void'(qc.pop_front());
         if (exp_ack) begin
            case (d)
               2'd0: m_drop = (m_drop < 255) ? m_drop + 1 : 255;
               2'd1: qa.push_back(m);
               2'd2: qb.push_back(m);
               default: qc.push_back(m);
            endcase
         end
      end
   endtask

   task automatic idle(input logic aa, input logic ab, input logic ac);
      step(IDLE, 2'd0, aa, ab, ac, 1'b1);
   endtask

   initial begin
      rst_n = 1'b0; msgin = IDLE; msgdst = 2'd0;
      msga_ack = 1'b0; msgb_ack = 1'b0; msgc_ack = 1'b0;
      repeat (2) @(posedge clk);

      // Basic push to a, then pop.
      idle(0, 0, 0);
      step(6'd5, 2'd1, 0, 0, 0, 1);
      idle(1, 0, 0);
      idle(0, 0, 0);

      // Stall b, fill it, overflow attempt held.
      step(6'd10, 2'd2, 0, 0, 0, 1);
      step(6'd11, 2'd2, 0, 0, 0, 1);
      step(6'd12, 2'd2, 0, 0, 0, 1);
      step(6'd12, 2'd2, 0, 0, 0, 1);
      // b full: c still accepted.
      step(6'd20, 2'd3, 0, 0, 0, 1);
      idle(0, 0, 1);
      // Release b while 12 is still held (no push-through when full).
      step(6'd12, 2'd2, 0, 1, 0, 1);
      step(6'd12, 2'd2, 0, 1, 0, 1);
      idle(0, 1, 0);
      idle(0, 0, 0);

      // Discards saturate the drop counter.
      for (int i = 0; i < 300; i++)
         step(6'($urandom_range(0, 62)), 2'd0, 0, 0, 0, 1);
      idle(0, 0, 0);
      check_eq("drop_sat", {24'd0, drop_count}, 32'd255);

      // Simultaneous push and pop on a one-entry channel.
      step(6'd7, 2'd1, 0, 0, 0, 1);
      step(6'd8, 2'd1, 1, 0, 0, 1);
      idle(1, 0, 0);
      idle(0, 0, 0);

      // Mid-operation reset discards buffered data.
      step(6'd1, 2'd1, 0, 0, 0, 1);
      step(6'd2, 2'd1, 0, 0, 0, 1);
      step(6'd3, 2'd1, 0, 0, 0, 0);
      idle(0, 0, 0);
      step(6'd9, 2'd1, 0, 0, 0, 1);
      idle(0, 0, 0);
      idle(1, 0, 0);

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         logic [5:0] m;
         m = ($urandom_range(0, 3) == 0) ? IDLE : 6'($urandom_range(0, 62));
         step(m, 2'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)),
              ($urandom_range(0, 199) != 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/msg_splitter3_narrow.md
Name: msg_splitter3_narrow

Overview:
- Inverse of the narrow 3-way message joiner: takes one narrow message stream plus a 2-bit destination code and steers each message to one of three narrow output channels (a, b, c).
- Each output channel has its own small FIFO, so a stalled consumer does not block traffic to the other channels unless its own FIFO is full.
- Sits on the return/response path of the narrow bus, between the shared narrow link and three per-client consumers.

Parameters:
- WBUFS, 6, message width in bits; the all-ones value is the idle (not-legal) code.
- DEPTH_LOG, 1, log2 of per-channel FIFO depth (default depth 2).
- NOTLEGAL, (1<<WBUFS)-1, derived idle code; not overridden.

Ports:
- clk  input  1  clock
- rst_n  input  1  synchronous active-low reset
- msgin  input  WBUFS  incoming message; NOTLEGAL means no message
- msgdst  input  2  destination: 1=a, 2=b, 3=c, 0=discard; valid only when msgin!=NOTLEGAL
- msgin_ack  output  1  message on msgin consumed this cycle
- msga  output  WBUFS  channel a head; NOTLEGAL when empty
- msgb  output  WBUFS  channel b head; NOTLEGAL when empty
- msgc  output  WBUFS  channel c head; NOTLEGAL when empty
- msga_ack  input  1  consumer a takes msga this cycle
- msgb_ack  input  1  consumer b takes msgb this cycle
- msgc_ack  input  1  consumer c takes msgc this cycle
- drop_count  output  8  count of messages discarded with msgdst=0; saturates at 255

Behaviour:
- Handshake (same on both sides): a message is valid when its value != NOTLEGAL. The consumer asserts ack combinationally in the same cycle. The transfer happens at the rising clk edge where valid && ack. The producer holds the message until that edge.
- msgin_ack is combinational:
  - msgin!=NOTLEGAL && rst_n && (msgdst==0 || FIFO[msgdst] count < 2^DEPTH_LOG).
  - It never depends on any msgX_ack. There is no full-FIFO push-through on simultaneous pop.
  - It is 0 whenever msgin==NOTLEGAL.
- Push: on a clk edge with msgin_ack=1 and msgdst in 1..3, write msgin into the selected FIFO tail. Exactly one FIFO is written per cycle.
- Discard: on a clk edge with msgin_ack=1 and msgdst=0, the message is consumed and dropped, and drop_count increments. drop_count saturates at 255 and does not wrap.
- Outputs:
  - msgX = FIFO head data when count>0, else NOTLEGAL.
  - msgX is driven from registered storage, with no combinational path from msgin to msgX.
  - Minimum latency from msgin accepted to visible on msgX is 1 cycle.
- Pop: on a clk edge with msgX_ack=1 and msgX!=NOTLEGAL, advance the FIFO head. A msgX_ack while empty is ignored, with no underflow and no pointer change.
- Simultaneous push and pop on the same channel when not full: count is unchanged and both pointers advance. When count==0, the pushed message appears next cycle.
- Pointers are DEPTH_LOG bits and wrap naturally. Count is DEPTH_LOG+1 bits, range 0..2^DEPTH_LOG.
- Independent channels: pops on a, b and c may all occur in the same cycle as a push to any channel.
- Ordering: per-channel FIFO order is preserved. There is no ordering guarantee across channels.
- Reset (rst_n low at clk edge):
  - All counts and pointers are cleared and drop_count=0.
  - msga, msgb and msgc read NOTLEGAL from the next cycle.
  - msgin_ack=0 while rst_n is low.
  - Reset mid-operation discards all buffered messages with no ack to any consumer for them.
- FIFO data storage needs no reset; only pointers and counts are reset.

Test Plan:
- Reset, then msgin=5 with msgdst=1 for one cycle -> msgin_ack=1. Next cycle msga=5 while msgb=msgc=63. Assert msga_ack -> msga=63 the following cycle.
- Stall channel b (msgb_ack=0) and send 3 messages 10, 11, 12 to b -> first two acked; third sees msgin_ack=0 while held. Raise msgb_ack -> msgb yields 10, 11, then 12 is accepted and appears.
- With channel b full, send a message to c -> accepted immediately, msgc valid next cycle; b is unaffected.
- Send 300 messages with msgdst=0 -> every one acked, no output changes, drop_count ends at 255.
- With channel a holding one entry (msga=7), push 8 to a and assert msga_ack in the same cycle -> next cycle msga=8 and count stays 1.
- Fill a with 2 entries, then pulse rst_n low for one cycle -> msga=63, drop_count=0; a subsequent push to a works normally.
